// File: rtl/hex_display_pkg.sv
// Shared types and constants for the time-multiplexed HEX display scheduler.
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] BLANK_SEGMENTS = 7'h7F;
  localparam int         NIBBLE_W       = 4;
  localparam int         SEG_W          = 7;

endpackage

// File: rtl/hex_display_scheduler.sv
// Shares one external seven-segment decoder across NUM_DIGITS HEX displays.
// Optional leading-zero blanking is compiled in with HEX_LEADING_ZERO_SUPPRESS_EN.
module hex_display_scheduler
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DWELL      = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]         i_blank_mask,
  output logic [NIBBLE_W-1:0]           o_dec_binary,
  input  logic [SEG_W-1:0]              i_dec_display,
  output logic [SEG_W*NUM_DIGITS-1:0]   o_hex,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL - 1);

  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [DW_W-1:0]  dwell;
  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] val_snap;
  logic [NUM_DIGITS-1:0]               blank_snap;
  logic [NUM_DIGITS-1:0]               lz_mask;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]    hex_q;
  logic xfer, step, last;

  assign xfer = (state == IDLE) && i_valid;
  assign step = (state == SCAN) && (dwell == LAST_DW);
  assign last = step && (idx == LAST_IDX);

`ifdef HEX_LEADING_ZERO_SUPPRESS_EN
  // Digit k>0 blanks when it and every more significant nibble are zero.
  always_comb begin
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (i_value[k*NIBBLE_W +: NIBBLE_W] == '0);
      lz_mask[k] = zero_above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = SCAN;
      end
      SCAN: begin
        o_busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx        <= '0;
      dwell      <= '0;
      val_snap   <= '0;
      blank_snap <= '0;
      hex_q      <= {NUM_DIGITS{BLANK_SEGMENTS}};
    end else if (xfer) begin
      val_snap   <= i_value;
      blank_snap <= i_blank_mask | lz_mask;
      idx        <= '0;
      dwell      <= '0;
    end else if (state == SCAN) begin
      if (step) begin
        hex_q[idx] <= blank_snap[idx] ? BLANK_SEGMENTS : i_dec_display;
        dwell      <= '0;
        idx        <= last ? '0 : idx + IDX_W'(1);
      end else begin
        dwell <= dwell + DW_W'(1);
      end
    end
  end

  // Decoder input only moves during a scan so the shared decoder stays quiet otherwise.
  assign o_dec_binary = (state == SCAN) ? val_snap[idx] : '0;
  assign o_hex        = hex_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench: DUT a (DWELL=1) and DUT b (DWELL=3), each with a behavioural decoder.
module tb_hex_display_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  logic        a_valid, a_ready, a_busy, a_done;
  logic [23:0] a_value;
  logic [5:0]  a_mask;
  logic [3:0]  a_dec_bin;
  logic [6:0]  a_dec_disp;
  logic [41:0] a_hex;

  logic        b_valid, b_ready, b_busy, b_done;
  logic [23:0] b_value;
  logic [5:0]  b_mask;
  logic [3:0]  b_dec_bin;
  logic [6:0]  b_dec_disp;
  logic [41:0] b_hex;

  assign a_dec_disp = seg7(a_dec_bin);
  assign b_dec_disp = seg7(b_dec_bin);

  hex_display_scheduler #(.NUM_DIGITS(6), .DWELL(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
    .i_value(a_value), .i_blank_mask(a_mask), .o_dec_binary(a_dec_bin),
    .i_dec_display(a_dec_disp), .o_hex(a_hex), .o_busy(a_busy), .o_done(a_done)
  );

  hex_display_scheduler #(.NUM_DIGITS(6), .DWELL(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
    .i_value(b_value), .i_blank_mask(b_mask), .o_dec_binary(b_dec_bin),
    .i_dec_display(b_dec_disp), .o_hex(b_hex), .o_busy(b_busy), .o_done(b_done)
  );

  // Offers a value to DUT a for exactly one edge; returns at the negedge after that edge.
  task automatic xfer_a(input logic [23:0] v, input logic [5:0] m);
    @(negedge clk);
    a_value = v; a_mask = m; a_valid = 1'b1;
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL xfer_a_ready: got %b expected 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // Waits for o_done on DUT a; observation c is the negedge after edge T0+c.
  task automatic wait_done_a(output int done_at, output int busy_cnt);
    done_at = -1; busy_cnt = 0;
    for (int c = 0; c <= 40 && done_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (a_busy) busy_cnt++;
      if (a_done) done_at = c;
    end
  endtask

  task automatic test_reset;
    xfer_a(24'h888888, 6'b0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (a_hex[6:0] !== 7'h00) begin n_fail++; $display("FAIL reset_pre_hex0: got %h expected 00", a_hex[6:0]); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_mid: got %b expected 0", a_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (a_hex !== {6{7'h7F}}) begin n_fail++; $display("FAIL reset_hex: got %h expected all 7F", a_hex); end
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    n_checks++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", a_done); end
    n_checks++;
    if (a_dec_bin !== 4'h0) begin n_fail++; $display("FAIL reset_dec_bin: got %h expected 0", a_dec_bin); end
  endtask

  task automatic test_basic_scan;
    int done_at, busy_cnt;
    xfer_a(24'h012345, 6'b0);
    wait_done_a(done_at, busy_cnt);
    n_checks++;
    if (done_at !== 6) begin n_fail++; $display("FAIL basic_done_time: got %0d expected 6", done_at); end
    n_checks++;
    if (busy_cnt !== 6) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 6", busy_cnt); end
    n_checks++;
    if (a_hex[6:0] !== 7'h12) begin n_fail++; $display("FAIL basic_hex0: got %h expected 12", a_hex[6:0]); end
    n_checks++;
    if (a_hex[27:21] !== 7'h24) begin n_fail++; $display("FAIL basic_hex3: got %h expected 24", a_hex[27:21]); end
    n_checks++;
`ifdef HEX_LEADING_ZERO_SUPPRESS_EN
    if (a_hex[41:35] !== 7'h7F) begin n_fail++; $display("FAIL basic_hex5: got %h expected 7F", a_hex[41:35]); end
`else
    if (a_hex[41:35] !== 7'h40) begin n_fail++; $display("FAIL basic_hex5: got %h expected 40", a_hex[41:35]); end
`endif
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b1 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_after_done: got ready=%b done=%b expected 1/0", a_ready, a_done);
    end
  endtask

  task automatic test_dwell;
    int first_at[6];
    int done_at, busy_cnt;
    for (int k = 0; k < 6; k++) first_at[k] = -1;
    @(negedge clk);
    b_value = 24'h888888; b_mask = 6'b0; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    done_at = -1; busy_cnt = 0;
    for (int c = 0; c <= 60 && done_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (b_busy) busy_cnt++;
      if (b_done) done_at = c;
      for (int k = 0; k < 6; k++)
        if (first_at[k] < 0 && b_hex[k*7 +: 7] == 7'h00) first_at[k] = c;
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (first_at[k] != 3 * (k + 1)) begin
        n_fail++; $display("FAIL dwell_slice%0d_time: got %0d expected %0d", k, first_at[k], 3 * (k + 1));
      end
    end
    n_checks++;
    if (done_at !== 18) begin n_fail++; $display("FAIL dwell_done_time: got %0d expected 18", done_at); end
    n_checks++;
    if (busy_cnt !== 18) begin n_fail++; $display("FAIL dwell_busy_cycles: got %0d expected 18", busy_cnt); end
  endtask

  task automatic test_blank_mask;
    int done_at, busy_cnt;
    logic [6:0] exp_seg;
    xfer_a(24'hFFFFFF, 6'b101010);
    wait_done_a(done_at, busy_cnt);
    n_checks++;
    if (done_at !== 6) begin n_fail++; $display("FAIL blank_done_time: got %0d expected 6", done_at); end
    for (int k = 0; k < 6; k++) begin
      exp_seg = (k % 2 == 1) ? 7'h7F : 7'h0E;
      n_checks++;
      if (a_hex[k*7 +: 7] !== exp_seg) begin
        n_fail++; $display("FAIL blank_hex%0d: got %h expected %h", k, a_hex[k*7 +: 7], exp_seg);
      end
    end
  endtask

  task automatic test_handshake;
    logic [23:0] last_val, v;
    logic [41:0] exp_hex;
    int last_cyc, nx, nd;
    logic [3:0] c4;
    @(negedge clk);
    last_val = '0; last_cyc = 0; nx = 0; nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      c4 = c[3:0];
      v = {4'h9, 20'h13579 ^ {5{c4}}};
      a_value = v; a_mask = 6'b0; a_valid = 1'b1;
      if (a_done) begin
        nd++;
        for (int k = 0; k < 6; k++) exp_hex[k*7 +: 7] = seg7(last_val[k*4 +: 4]);
        n_checks++;
        if (a_hex !== exp_hex) begin n_fail++; $display("FAIL hs_display%0d: got %h expected %h", nd, a_hex, exp_hex); end
      end
      if (a_ready) begin
        if (nx > 0) begin
          n_checks++;
          if (c - last_cyc != 8) begin n_fail++; $display("FAIL hs_spacing%0d: got %0d expected 8", nx, c - last_cyc); end
        end
        last_val = v; last_cyc = c; nx++;
      end
    end
    a_valid = 1'b0;
    n_checks++;
    if (nx != 4) begin n_fail++; $display("FAIL hs_transfer_count: got %0d expected 4", nx); end
    n_checks++;
    if (nd != 3) begin n_fail++; $display("FAIL hs_done_count: got %0d expected 3", nd); end
    // Let the transfer in flight finish so later tests start in IDLE.
    repeat (10) @(negedge clk);
  endtask

`ifdef HEX_LEADING_ZERO_SUPPRESS_EN
  task automatic test_lzs;
    int done_at, busy_cnt;
    logic [41:0] exp_a, exp_z;
    exp_a = {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12};
    exp_z = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    xfer_a(24'h000A05, 6'b0);
    wait_done_a(done_at, busy_cnt);
    n_checks++;
    if (a_hex !== exp_a) begin n_fail++; $display("FAIL lzs_a05: got %h expected %h", a_hex, exp_a); end
    xfer_a(24'h000000, 6'b0);
    wait_done_a(done_at, busy_cnt);
    n_checks++;
    if (a_hex !== exp_z) begin n_fail++; $display("FAIL lzs_zero: got %h expected %h", a_hex, exp_z); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_value = '0; a_mask = '0;
    b_valid = 1'b0; b_value = '0; b_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_basic_scan;
    test_dwell;
    test_blank_mask;
    test_handshake;
`ifdef HEX_LEADING_ZERO_SUPPRESS_EN
    test_lzs;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
- Time-shares one combinational seven-segment `decoder` among NUM_DIGITS HEX displays of a DE10 Lite (HEX0..HEX5).
- Accepts a multi-nibble value over a valid/ready handshake, snapshots it, then steps through the digits. For each digit it drives the shared decoder and latches the decoder's segment output into that digit's output register.
- Sits between application logic (counters, register readback) and the HEX pins. The decoder instance stays outside this block, fed through the o_dec_*/i_dec_* ports.

Parameters:
- NUM_DIGITS, 6, number of displays served (1..8).
- DWELL, 1, clock cycles the decoder input is held per digit before its output is captured (>=1).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  synchronous, active-low reset.
- i_valid  input  1  new value offered.
- o_ready  output  1  block can accept a value (high only in IDLE).
- i_value  input  4*NUM_DIGITS  value to display; nibble k -> digit k (k=0 is HEX0, least significant).
- i_blank_mask  input  NUM_DIGITS  bit k=1 forces digit k blank; sampled with i_value.
- o_dec_binary  output  4  nibble driven to the shared decoder.
- i_dec_display  input  7  segment pattern returned by the shared decoder (active-low).
- o_hex  output  7*NUM_DIGITS  registered segment patterns; slice k drives HEXk.
- o_busy  output  1  scan in progress.
- o_done  output  1  one-cycle pulse when all digits have been updated.

Behaviour:
Reset (i_rst_n low at a clock edge, any state, including mid-scan):
- State goes to IDLE.
- o_hex = all 7'h7F (blank); o_busy=0; o_done=0; o_ready=1; o_dec_binary=0.
- Digit index, dwell counter and snapshot registers are cleared.

FSM states: IDLE, SCAN, DONE.
- IDLE:
  - o_ready=1, o_busy=0.
  - A transfer occurs when i_valid && o_ready at a clock edge. The block then snapshots i_value and i_blank_mask, sets index=0 and dwell=0, and goes to SCAN.
  - i_valid without a transfer is ignored. Nothing is queued.
- SCAN:
  - o_ready=0, o_busy=1.
  - o_dec_binary = snapshot nibble[index], combinational from registers.
  - dwell increments each cycle. On the edge where dwell==DWELL-1:
    - o_hex[index] <= blank_snap[index] ? 7'h7F : i_dec_display;
    - dwell <= 0, index <= index+1.
  - After index NUM_DIGITS-1 is written, the FSM goes to DONE.
  - i_valid is ignored during SCAN.
- DONE:
  - o_done=1 for exactly this cycle; o_busy=0, o_ready=0.
  - Next state is IDLE unconditionally.

Timing:
- Latency from the transfer edge to the last o_hex write is NUM_DIGITS*DWELL cycles.
- o_done is high in the cycle after the last write.
- o_ready returns one cycle after o_done.

Output holding:
- o_hex slices not yet rewritten hold their previous values.
- Each slice changes at most once per scan, so there are no glitch sequences.

Arithmetic:
- index is $clog2(NUM_DIGITS) bits wide (minimum 1); dwell is $clog2(DWELL) bits wide (minimum 1).
- index never wraps inside a scan. The compare is against NUM_DIGITS-1, not a power of two.

Optional Feature:
- Macro HEX_LEADING_ZERO_SUPPRESS_EN.
- When defined, at the transfer edge the block computes an extra blank mask. A digit k>0 is blanked if nibble k and every higher nibble are zero. Digit 0 is never suppressed. This mask is OR-ed into the sampled i_blank_mask.
- Example: 24'h00_0A05 shows "A05" on HEX2..HEX0, with HEX5..HEX3 blank.
- When not defined, only i_blank_mask blanks digits, and leading zeros display as '0'.

Decomposition:
- Package hex_display_pkg holds:
  - state enum type: IDLE, SCAN, DONE;
  - constant BLANK_SEGMENTS = 7'h7F;
  - constant NIBBLE_W = 4;
  - constant SEG_W = 7.
- No sub-module is needed. The existing `decoder` is instantiated beside this block at top level, e.g. in decoder_de10_lite's successor.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles mid-scan (value 24'h888888, DWELL=1, reset at cycle 3) -> next cycle o_hex=all 7'h7F, o_busy=0, o_ready=1, o_done=0.
- Basic scan: bench uses the real decoder; DWELL=1, i_value=24'h012345, mask=0 -> o_done exactly 7 cycles after the transfer edge. Then HEX0 holds the '5' pattern and HEX5 holds 7'b1000000 ('0').
- Dwell: DWELL=3, i_value=24'h888888 -> each slice becomes 7'b0000000 at 3-cycle spacing; o_done 19 cycles after transfer; o_busy high for 18 cycles.
- Blank mask: i_value=24'hFFFFFF, i_blank_mask=6'b101010 -> HEX1, HEX3, HEX5 = 7'h7F; HEX0, HEX2, HEX4 = the 'F' pattern.
- Handshake: hold i_valid=1 continuously with value changing every cycle -> transfers only on cycles where o_ready=1, i.e. every NUM_DIGITS*DWELL+2 cycles. The displayed value equals the value present at each transfer edge.
- LZS (macro defined): i_value=24'h000A05 -> HEX5..HEX3 = 7'h7F; HEX2..HEX0 show A, 0, 5. For i_value=0, HEX0 shows '0' and all others are blank.
